alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Command-side driver and checker for the 7-bit ALU datapath. It accepts operation commands over a valid/ready handshake and drives registered operands and opcode into the ALU. One cycle later it captures the ALU result and flags and checks them against an internal reference model. Captured responses are buffered in a small FIFO for a downstream consumer. It sits between the host/test sequencer and the combinational ALU and owns all ALU stimulus timing.

## Interface
- W, 7, operand width; result width is W+1.
- DEPTH, 4, response FIFO depth (power of two, ≥2).

- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at clk edge.
- cmd_a, cmd_b  in  W  operands.
- cmd_op  in  2  00 add, 01 sub, 10 and, 11 or.
- alu_a, alu_b  out  W  registered operands to ALU.
- alu_op  out  2  registered opcode to ALU.
- alu_res  in  W+1  ALU result.
- alu_carry, alu_ovf, alu_zero  in  1  ALU flags.
- rsp_valid  out  1  FIFO head valid.
- rsp_ready  in  1  consumer pops head when rsp_valid & rsp_ready.
- rsp_data  out  W+1  captured result at FIFO head.
- rsp_flags  out  4  {err, carry, ovf, zero} at FIFO head.
- sticky_flags  out  4  OR of all captured rsp_flags since reset/clear.
- sticky_clr  in  1  clears sticky_flags.
- op_count  out  8  captured-operation counter, wraps 255→0.

## Operation
- FSM states are IDLE and DRIVE.
- IDLE: cmd_ready = (count + 0) < DEPTH. On accept, register cmd_a/b/op onto alu_a/b/op and go to DRIVE.
- DRIVE: cmd_ready = 0. At the next edge, sample alu_res and the flags, push {flags, err, res} into the FIFO, increment op_count, update sticky, and return to IDLE.
- Throughput is one command per 2 cycles.
- FIFO slot reservation: acceptance requires free space at accept time. A push never finds the FIFO full, because pops can only free space.
- Reference model, all arithmetic modulo 2^(W+1), operands zero-extended to W+1 bits:
  - add: exp = A+B; carry = exp[W].
  - sub: exp = A + (~B + 1) = A−B mod 2^(W+1); ovf = (A[W-1]&~B[W-1]&~exp[W-1]) | (~A[W-1]&B[W-1]&exp[W-1]).
  - and/or: exp = {0, A&B} or {0, A|B}.
  - Flags not defined for the op are 0. zero = (exp == 0).
- err = 1 when alu_res, alu_carry, alu_ovf or alu_zero differ from the model. The stored carry/ovf/zero fields are the ALU's values, not the model's.
- Simultaneous push and pop: both take effect; count unchanged.
- sticky_clr coincident with a capture: sticky_flags ← new flags (the capture wins over the clear).
- alu_a/b/op hold their last values in IDLE.

## Timing
- Reset (rst_n low, asynchronous): FSM to IDLE; FIFO emptied; any in-flight command is discarded.
- Output values during and after reset:
  - alu_a = alu_b = 0, alu_op = 00.
  - rsp_valid = 0, rsp_data = 0, rsp_flags = 0.
  - sticky_flags = 0, op_count = 0.
  - cmd_ready = 1 once in IDLE with an empty FIFO.
- Accept at edge E0 → alu_* valid after E0 → capture at E1 → rsp_valid = 1 after E1. Latency is 2 edges from accept to response.
- The FIFO is show-ahead: rsp_data/rsp_flags are valid whenever rsp_valid = 1 and stable until popped.
- cmd_ready is combinational from state and FIFO count, not from cmd_valid.
- Reset mid-DRIVE: no capture occurs and op_count is not incremented.

## Test plan
- Add: A=100, B=50, op 00 → rsp_data=0x96, rsp_flags=0100 (carry=1), rsp_valid exactly 2 edges after accept, op_count=1.
- Sub with overflow: A=0x4E, B=0x1E, op 01 → rsp_data=0x30, ovf=1, err=0. Sub without overflow: A=0x6C, B=0x1E → rsp_data=0x4E, ovf=0.
- Logic ops: AND 0x55, 0x0F → 0x05, flags 0000. OR 0x00, 0x00 → 0x00, zero=1, sticky_flags=0001.
- Backpressure: hold rsp_ready=0 and offer 5 commands → exactly 4 accepted and cmd_ready stays 0. Pop one → next command accepted; responses emerge in order and unchanged.
- Checker: bench returns alu_res+1 for one add → err=1 in rsp_flags and sticky_flags[3]=1. Assert sticky_clr on the same edge as the next clean capture → sticky holds only the new flags.
- Reset mid-DRIVE and counter wrap: drop rst_n during DRIVE → rsp_valid=0, op_count=0, alu_*=0 immediately. Run 256 operations afterwards → op_count wraps to 0.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Command-side driver and checker for the W-bit ALU: registers operands onto the ALU,
// captures result/flags one cycle later, checks them and queues responses in a FIFO.
module alu_op_sequencer #(
    parameter int unsigned W     = 7,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_cmd_valid,
    output logic         o_cmd_ready,
    input  logic [W-1:0] i_cmd_a,
    input  logic [W-1:0] i_cmd_b,
    input  logic [1:0]   i_cmd_op,
    output logic [W-1:0] o_alu_a,
    output logic [W-1:0] o_alu_b,
    output logic [1:0]   o_alu_op,
    input  logic [W:0]   i_alu_res,
    input  logic         i_alu_carry,
    input  logic         i_alu_ovf,
    input  logic         i_alu_zero,
    output logic         o_rsp_valid,
    input  logic         i_rsp_ready,
    output logic [W:0]   o_rsp_data,
    output logic [3:0]   o_rsp_flags,
    output logic [3:0]   o_sticky_flags,
    input  logic         i_sticky_clr,
    output logic [7:0]   o_op_count
);
    localparam int unsigned RW = W + 1;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DRIVE = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_cmd_ready;
    logic          w_accept;
    logic          w_capture;

    logic [W-1:0]  r_alu_a;
    logic [W-1:0]  r_alu_b;
    logic [1:0]    r_alu_op;

    logic [RW-1:0] w_a_ext;
    logic [RW-1:0] w_b_ext;
    logic [RW-1:0] w_exp;
    logic          w_exp_carry;
    logic          w_exp_ovf;
    logic          w_exp_zero;
    logic          w_err;
    logic [3:0]    w_flags;

    logic [RW-1:0] r_mem_data  [DEPTH];
    logic [3:0]    r_mem_flags [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    logic [3:0]    r_sticky;
    logic [7:0]    r_op_count;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake; only one command in flight, so IDLE needs just one free slot
    always_comb begin
        w_state_nxt = r_state;
        w_cmd_ready = 1'b0;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cmd_ready = (r_count < CW'(DEPTH));
                w_accept    = i_cmd_valid & w_cmd_ready;
                if (w_accept) begin
                    w_state_nxt = S_DRIVE;
                end
            end
            default: begin
                w_capture   = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ALU stimulus registers, held while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_op <= 2'b00;
        end else if (w_accept) begin
            r_alu_a  <= i_cmd_a;
            r_alu_b  <= i_cmd_b;
            r_alu_op <= i_cmd_op;
        end
    end

    // Reference model of the ALU on the currently driven operands
    always_comb begin
        w_a_ext     = RW'(r_alu_a);
        w_b_ext     = RW'(r_alu_b);
        w_exp       = '0;
        w_exp_carry = 1'b0;
        w_exp_ovf   = 1'b0;
        case (r_alu_op)
            2'b00: begin
                w_exp       = w_a_ext + w_b_ext;
                w_exp_carry = w_exp[W];
            end
            2'b01: begin
                w_exp     = w_a_ext + (~w_b_ext + RW'(1));
                w_exp_ovf = (r_alu_a[W-1] & ~r_alu_b[W-1] & ~w_exp[W-1]) |
                            (~r_alu_a[W-1] & r_alu_b[W-1] & w_exp[W-1]);
            end
            2'b10:   w_exp = w_a_ext & w_b_ext;
            default: w_exp = w_a_ext | w_b_ext;
        endcase
        w_exp_zero = (w_exp == '0);
        w_err      = (i_alu_res != w_exp) | (i_alu_carry != w_exp_carry) |
                     (i_alu_ovf != w_exp_ovf) | (i_alu_zero != w_exp_zero);
        w_flags    = {w_err, i_alu_carry, i_alu_ovf, i_alu_zero};
    end

    assign w_push = w_capture;
    assign w_pop  = o_rsp_valid & i_rsp_ready;

    // Response FIFO storage, show-ahead read at r_rd_ptr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem_data[i]  <= '0;
                r_mem_flags[i] <= '0;
            end
        end else if (w_push) begin
            r_mem_data[r_wr_ptr]  <= i_alu_res;
            r_mem_flags[r_wr_ptr] <= w_flags;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Sticky flags and operation counter; a capture overrides a coincident clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky   <= '0;
            r_op_count <= '0;
        end else begin
            if (w_capture) begin
                r_sticky   <= (i_sticky_clr ? 4'b0000 : r_sticky) | w_flags;
                r_op_count <= r_op_count + 8'd1;
            end else if (i_sticky_clr) begin
                r_sticky <= '0;
            end
        end
    end

    assign o_cmd_ready    = w_cmd_ready;
    assign o_alu_a        = r_alu_a;
    assign o_alu_b        = r_alu_b;
    assign o_alu_op       = r_alu_op;
    assign o_rsp_valid    = (r_count != '0);
    assign o_rsp_data     = r_mem_data[r_rd_ptr];
    assign o_rsp_flags    = r_mem_flags[r_rd_ptr];
    assign o_sticky_flags = r_sticky;
    assign o_op_count     = r_op_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: behavioural ALU with fault injection,
// table-driven vectors, hand-written corner sequences and a randomized scoreboard run.
module tb_alu_op_sequencer;
    logic       clk;
    logic       rst_n;
    logic       i_cmd_valid;
    logic       o_cmd_ready;
    logic [6:0] i_cmd_a;
    logic [6:0] i_cmd_b;
    logic [1:0] i_cmd_op;
    logic [6:0] o_alu_a;
    logic [6:0] o_alu_b;
    logic [1:0] o_alu_op;
    logic [7:0] i_alu_res;
    logic       i_alu_carry;
    logic       i_alu_ovf;
    logic       i_alu_zero;
    logic       o_rsp_valid;
    logic       i_rsp_ready;
    logic [7:0] o_rsp_data;
    logic [3:0] o_rsp_flags;
    logic [3:0] o_sticky_flags;
    logic       i_sticky_clr;
    logic [7:0] o_op_count;

    alu_op_sequencer #(.W(7), .DEPTH(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_cmd_valid    (i_cmd_valid),
        .o_cmd_ready    (o_cmd_ready),
        .i_cmd_a        (i_cmd_a),
        .i_cmd_b        (i_cmd_b),
        .i_cmd_op       (i_cmd_op),
        .o_alu_a        (o_alu_a),
        .o_alu_b        (o_alu_b),
        .o_alu_op       (o_alu_op),
        .i_alu_res      (i_alu_res),
        .i_alu_carry    (i_alu_carry),
        .i_alu_ovf      (i_alu_ovf),
        .i_alu_zero     (i_alu_zero),
        .o_rsp_valid    (o_rsp_valid),
        .i_rsp_ready    (i_rsp_ready),
        .o_rsp_data     (o_rsp_data),
        .o_rsp_flags    (o_rsp_flags),
        .o_sticky_flags (o_sticky_flags),
        .i_sticky_clr   (i_sticky_clr),
        .o_op_count     (o_op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic [3:0] f;
    } rsp_t;

    typedef struct {
        logic [6:0] a;
        logic [6:0] b;
        logic [1:0] op;
        logic [7:0] d;
        logic [3:0] f;
    } vec_t;

    int         n_checks = 0;
    int         n_err    = 0;
    rsp_t       exp_q[$];
    logic [7:0] m_count;
    logic [3:0] m_sticky;
    logic [1:0] inj_kind;   // 0 clean, 1 result+1, 2 carry flipped, 3 zero flipped
    logic [10:0] alu_ref;
    bit         done;

    // Integer-arithmetic ALU: returns {zero, ovf, carry, result}
    function automatic logic [10:0] ref_alu(input logic [6:0] a, input logic [6:0] b,
                                            input logic [1:0] op);
        int   ai, bi, r;
        logic c, v;
        ai = int'(a);
        bi = int'(b);
        r  = 0;
        c  = 1'b0;
        v  = 1'b0;
        case (op)
            2'd0: begin
                r = ai + bi;
                c = (r >= 128);
            end
            2'd1: begin
                r = (ai - bi + 256) % 256;
                v = ((ai >= 64) && (bi < 64) && ((r % 128) < 64)) ||
                    ((ai < 64) && (bi >= 64) && ((r % 128) >= 64));
            end
            2'd2:    r = ai & bi;
            default: r = ai | bi;
        endcase
        return {(r == 0), v, c, 8'(r)};
    endfunction

    // Behavioural ALU driven by the DUT, with optional corruption
    always_comb begin
        alu_ref     = ref_alu(o_alu_a, o_alu_b, o_alu_op);
        i_alu_res   = alu_ref[7:0] + 8'(inj_kind == 2'd1);
        i_alu_carry = alu_ref[8] ^ (inj_kind == 2'd2);
        i_alu_ovf   = alu_ref[9];
        i_alu_zero  = alu_ref[10] ^ (inj_kind == 2'd3);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Offer a command until accepted or max_cyc edges pass; returns at accept edge + 1
    task automatic send(input logic [6:0] a, input logic [6:0] b, input logic [1:0] op,
                        input int max_cyc, output bit ok);
        logic        rdy;
        int          n;
        logic [10:0] t;
        rsp_t        e;
        i_cmd_a     = a;
        i_cmd_b     = b;
        i_cmd_op    = op;
        i_cmd_valid = 1'b1;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < max_cyc) begin
            rdy = o_cmd_ready;
            @(posedge clk);
            #1;
            n++;
            if (rdy) ok = 1'b1;
        end
        i_cmd_valid = 1'b0;
        if (ok) begin
            t   = ref_alu(a, b, op);
            e.d = t[7:0] + 8'(inj_kind == 2'd1);
            e.f = {inj_kind != 2'd0, t[8] ^ (inj_kind == 2'd2), t[9], t[10] ^ (inj_kind == 2'd3)};
            exp_q.push_back(e);
            m_count  = m_count + 8'd1;
            m_sticky = m_sticky | e.f;
        end
    endtask

    // Wait for the head response, compare it with the scoreboard and pop it
    task automatic pop_check(input string name);
        int   n;
        rsp_t e;
        n = 0;
        while (!o_rsp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_valid"}, 32'(o_rsp_valid), 32'd1);
        check({name, "_model_has_entry"}, 32'(exp_q.size() > 0), 32'd1);
        if (o_rsp_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({name, "_data"}, 32'(o_rsp_data), 32'(e.d));
            check({name, "_flags"}, 32'(o_rsp_flags), 32'(e.f));
            i_rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            i_rsp_ready = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        bit   ok;

        tbl[0] = '{7'd100, 7'd50, 2'd0, 8'h96, 4'b0100};
        tbl[1] = '{7'h4E,  7'h1E, 2'd1, 8'h30, 4'b0010};
        tbl[2] = '{7'h6C,  7'h1E, 2'd1, 8'h4E, 4'b0000};
        tbl[3] = '{7'h55,  7'h0F, 2'd2, 8'h05, 4'b0000};
        tbl[4] = '{7'h00,  7'h00, 2'd3, 8'h00, 4'b0001};
        tbl[5] = '{7'h7F,  7'h7F, 2'd0, 8'hFE, 4'b0100};
        tbl[6] = '{7'h05,  7'h05, 2'd1, 8'h00, 4'b0001};
        tbl[7] = '{7'h00,  7'h01, 2'd1, 8'hFF, 4'b0000};
        tbl[8] = '{7'h01,  7'h41, 2'd1, 8'hC0, 4'b0010};
        tbl[9] = '{7'h2A,  7'h51, 2'd3, 8'h7B, 4'b0000};

        rst_n        = 1'b0;
        i_cmd_valid  = 1'b0;
        i_cmd_a      = '0;
        i_cmd_b      = '0;
        i_cmd_op     = '0;
        i_rsp_ready  = 1'b0;
        i_sticky_clr = 1'b0;
        inj_kind     = 2'd0;
        m_count      = '0;
        m_sticky     = '0;
        done         = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_alu_a", 32'(o_alu_a), 32'd0);
        check("rst_alu_b", 32'(o_alu_b), 32'd0);
        check("rst_alu_op", 32'(o_alu_op), 32'd0);
        check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(o_rsp_data), 32'd0);
        check("rst_rsp_flags", 32'(o_rsp_flags), 32'd0);
        check("rst_sticky", 32'(o_sticky_flags), 32'd0);
        check("rst_op_count", 32'(o_op_count), 32'd0);
        check("rst_cmd_ready", 32'(o_cmd_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven single operations with latency check
        for (int i = 0; i < 10; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].op, 20, ok);
            check($sformatf("vec%0d_accept", i), 32'(ok), 32'd1);
            check($sformatf("vec%0d_alu_a", i), 32'(o_alu_a), 32'(tbl[i].a));
            check($sformatf("vec%0d_alu_op", i), 32'(o_alu_op), 32'(tbl[i].op));
            check($sformatf("vec%0d_valid_after_1_edge", i), 32'(o_rsp_valid), 32'd0);
            check($sformatf("vec%0d_ready_in_drive", i), 32'(o_cmd_ready), 32'd0);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_valid_after_2_edges", i), 32'(o_rsp_valid), 32'd1);
            check($sformatf("vec%0d_data", i), 32'(o_rsp_data), 32'(tbl[i].d));
            check($sformatf("vec%0d_flags", i), 32'(o_rsp_flags), 32'(tbl[i].f));
            if (i == 0) check("vec0_op_count", 32'(o_op_count), 32'd1);
            pop_check($sformatf("vec%0d_pop", i));
        end
        check("table_op_count", 32'(o_op_count), 32'(m_count));
        check("table_sticky", 32'(o_sticky_flags), 32'(m_sticky));

        // Sticky clear alone, then OR 0,0 sets only zero
        i_sticky_clr = 1'b1;
        @(posedge clk);
        #1;
        i_sticky_clr = 1'b0;
        m_sticky     = '0;
        check("sticky_cleared", 32'(o_sticky_flags), 32'd0);
        send(7'h00, 7'h00, 2'd3, 20, ok);
        @(posedge clk);
        #1;
        check("or_zero_sticky", 32'(o_sticky_flags), 32'b0001);
        pop_check("or_zero_pop");

        // Checker: corrupted result sets err and sticky[3]
        inj_kind = 2'd1;
        send(7'd10, 7'd20, 2'd0, 20, ok);
        @(posedge clk);
        #1;
        inj_kind = 2'd0;
        check("inj_err_flag", 32'(o_rsp_flags[3]), 32'd1);
        check("inj_data", 32'(o_rsp_data), 32'd31);
        check("inj_sticky_err", 32'(o_sticky_flags[3]), 32'd1);
        pop_check("inj_pop");

        // Clear coincident with a clean capture keeps only the new flags
        m_sticky = '0;
        send(7'h00, 7'h7F, 2'd2, 20, ok);
        i_sticky_clr = 1'b1;
        @(posedge clk);
        #1;
        i_sticky_clr = 1'b0;
        check("clr_vs_capture_sticky", 32'(o_sticky_flags), 32'(m_sticky));
        check("clr_vs_capture_value", 32'(o_sticky_flags), 32'b0001);
        pop_check("clr_pop");

        // Backpressure: four accepted, fifth blocked until a pop
        for (int i = 0; i < 4; i++) begin
            send(7'(i * 17 + 3), 7'(i * 5 + 1), 2'(i), 20, ok);
            check($sformatf("bp_accept%0d", i), 32'(ok), 32'd1);
        end
        send(7'h33, 7'h22, 2'd0, 10, ok);
        check("bp_fifth_blocked", 32'(ok), 32'd0);
        check("bp_ready_low", 32'(o_cmd_ready), 32'd0);
        pop_check("bp_pop0");
        send(7'h33, 7'h22, 2'd0, 20, ok);
        check("bp_fifth_accepted", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        check("bp_full_again", 32'(o_cmd_ready), 32'd0);
        for (int i = 1; i < 5; i++) pop_check($sformatf("bp_pop%0d", i));

        // Reset while in DRIVE with a response still queued
        send(7'd1, 7'd2, 2'd0, 20, ok);
        @(posedge clk);
        #1;
        send(7'd3, 7'd4, 2'd0, 20, ok);
        check("pre_reset_valid", 32'(o_rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(o_rsp_valid), 32'd0);
        check("mid_rst_op_count", 32'(o_op_count), 32'd0);
        check("mid_rst_alu_a", 32'(o_alu_a), 32'd0);
        check("mid_rst_alu_b", 32'(o_alu_b), 32'd0);
        check("mid_rst_alu_op", 32'(o_alu_op), 32'd0);
        exp_q.delete();
        m_count  = '0;
        m_sticky = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_op_count", 32'(o_op_count), 32'd0);
        check("post_rst_valid", 32'(o_rsp_valid), 32'd0);

        // Randomized run of 256 operations with a random consumer; counter wraps
        fork
            begin
                for (int i = 0; i < 256; i++) begin
                    inj_kind = ($urandom_range(7) == 0) ? 2'($urandom_range(3, 1)) : 2'd0;
                    send(7'($urandom), 7'($urandom), 2'($urandom), 200, ok);
                    if (!ok) check($sformatf("rnd_accept%0d", i), 32'(ok), 32'd1);
                    @(posedge clk);
                    #1;
                    inj_kind = 2'd0;
                end
                for (int n = 0; n < 500 && exp_q.size() > 0; n++) begin
                    @(posedge clk);
                    #1;
                end
                check("rnd_drained", 32'(exp_q.size()), 32'd0);
                done = 1'b1;
            end
            begin
                rsp_t e;
                int   n;
                n = 0;
                while (!done && n < 20000) begin
                    i_rsp_ready = 1'($urandom);
                    if (i_rsp_ready && o_rsp_valid) begin
                        if (exp_q.size() > 0) begin
                            e = exp_q.pop_front();
                            check("rnd_data", 32'(o_rsp_data), 32'(e.d));
                            check("rnd_flags", 32'(o_rsp_flags), 32'(e.f));
                        end else begin
                            check("rnd_unexpected_rsp", 32'(o_rsp_valid), 32'd0);
                        end
                    end
                    @(posedge clk);
                    #1;
                    n++;
                end
                i_rsp_ready = 1'b0;
            end
        join
        check("rnd_op_count_wrap", 32'(o_op_count), 32'(m_count));
        check("rnd_sticky", 32'(o_sticky_flags), 32'(m_sticky));
        check("rnd_empty", 32'(o_rsp_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
